// File: rtl/clk_sw_pkg.sv
// Shared types and constants for the clock-switch sequencing controller.
package clk_sw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OFF,
    ST_ON,
    ST_SETTLE,
    ST_ABORT
  } state_t;

  localparam logic SEL_100M = 1'b0;
  localparam logic SEL_200M = 1'b1;

endpackage

// File: rtl/clk_switch_ctrl_if.sv
// Request/status bundle between a switch requester and the clock-switch controller.
// Handshake: a request transfers on a rising clock edge where req_valid and req_ready
// are both 1; req_sel must be stable while req_valid is high. done/err are one-cycle pulses.
interface clk_switch_ctrl_if;
  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic done;
  logic err;
  logic busy;
  logic cur_sel;

  modport master (
    output req_valid, req_sel,
    input  req_ready, done, err, busy, cur_sel
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, done, err, busy, cur_sel
  );
endinterface

// File: rtl/bit_sync.sv
// STAGES-deep flop chain bringing an asynchronous level into the local clock domain.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/clk_switch_ctrl.sv
// Break-before-make sequencer for the 100M/200M glitch-free clock mux gate enables,
// with status-edge timeouts and a post-switch settle interval.
module clk_switch_ctrl
  import clk_sw_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 63,
  parameter int SETTLE      = 8
) (
  input  logic               clk100M,
  input  logic               rst,
  clk_switch_ctrl_if.slave   req,
  output logic               en_100M,
  output logic               en_200M,
  input  logic               on_100M,
  input  logic               on_200M,
  output state_t             dbg_state
);

  localparam int TMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TIMEOUT_V   = TW'(TIMEOUT);
  localparam logic [TW-1:0] SETTLE_LAST = TW'((SETTLE == 0) ? 0 : SETTLE - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic          target;
  logic          s100, s200;
  logic          old_on, new_on, accept;
  logic          ready_q, done_q, err_q, busy_q, cur_q;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_100 (
    .clk (clk100M),
    .rst (rst),
    .d   (on_100M),
    .q   (s100)
  );

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_200 (
    .clk (clk100M),
    .rst (rst),
    .d   (on_200M),
    .q   (s200)
  );

  // The source being left is always the opposite of the stored target.
  assign old_on = (target == SEL_200M) ? s100 : s200;
  assign new_on = (target == SEL_200M) ? s200 : s100;
  assign accept = (state == ST_IDLE) && req.req_valid && ready_q;

  always_ff @(posedge clk100M) begin
    if (rst) begin
      state   <= ST_IDLE;
      timer   <= '0;
      target  <= SEL_100M;
      en_100M <= 1'b1;
      en_200M <= 1'b0;
      cur_q   <= SEL_100M;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          ready_q <= ~accept;
          if (accept) begin
            if (req.req_sel == cur_q) begin
              done_q <= 1'b1;
            end else begin
              target  <= req.req_sel;
              timer   <= '0;
              state   <= ST_OFF;
              busy_q  <= 1'b1;
              en_100M <= 1'b0;
              en_200M <= 1'b0;
            end
          end
        end
        ST_OFF: begin
          if (!old_on) begin
            state <= ST_ON;
            timer <= '0;
            if (target == SEL_200M) en_200M <= 1'b1;
            else                    en_100M <= 1'b1;
          end else if (timer == TIMEOUT_V) begin
            state   <= ST_ABORT;
            err_q   <= 1'b1;
            en_100M <= (target == SEL_200M);
            en_200M <= (target == SEL_100M);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_ON: begin
          if (new_on) begin
            state <= ST_SETTLE;
            timer <= '0;
          end else if (timer == TIMEOUT_V) begin
            state   <= ST_ABORT;
            err_q   <= 1'b1;
            en_100M <= (target == SEL_200M);
            en_200M <= (target == SEL_100M);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_SETTLE: begin
          // SETTLE = 0 still spends exactly one cycle here.
          if ((SETTLE == 0) || (timer == SETTLE_LAST)) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
            cur_q  <= target;
            busy_q <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_ABORT: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign req.req_ready = ready_q;
  assign req.done      = done_q;
  assign req.err       = err_q;
  assign req.busy      = busy_q;
  assign req.cur_sel   = cur_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl with a zero-delay mux model and stuck-status faults.
module tb_clk_switch_ctrl;
  import clk_sw_pkg::*;

  localparam int S  = 2;
  localparam int TO = 63;
  localparam int ST = 8;
  localparam int LAT_SW     = 3 + 2 * S + ST;
  localparam int LAT_OFF_TO = 2 + TO;
  localparam int LAT_ON_TO  = 3 + S + TO;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   en_100M, en_200M, on_100M, on_200M;
  logic   f100 = 1'b0, v100 = 1'b0, f200 = 1'b0, v200 = 1'b0;
  state_t dbg_state;

  clk_switch_ctrl_if ifc ();

  // Zero-delay mux: status follows enable unless a fault override is active.
  assign on_100M = f100 ? v100 : en_100M;
  assign on_200M = f200 ? v200 : en_200M;

  clk_switch_ctrl #(.SYNC_STAGES(S), .TIMEOUT(TO), .SETTLE(ST)) dut (
    .clk100M   (clk),
    .rst       (rst),
    .req       (ifc),
    .en_100M   (en_100M),
    .en_200M   (en_200M),
    .on_100M   (on_100M),
    .on_200M   (on_200M),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int   tests = 0, fails = 0;
  int   cyc = 0, n_done = 0, n_err = 0, n_busy = 0, viol = 0;
  int   fall100 = -1, rise100 = -1, fall200 = -1, rise200 = -1, t_acc = 0;
  logic p100 = 1'b1, p200 = 1'b0;

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (en_100M === 1'b1 && en_200M === 1'b1) viol++;
    if (ifc.done === 1'b1) n_done++;
    if (ifc.err === 1'b1) n_err++;
    if (ifc.busy === 1'b1) n_busy++;
    if (p100 === 1'b1 && en_100M === 1'b0) fall100 = cyc;
    if (p100 === 1'b0 && en_100M === 1'b1) rise100 = cyc;
    if (p200 === 1'b1 && en_200M === 1'b0) fall200 = cyc;
    if (p200 === 1'b0 && en_200M === 1'b1) rise200 = cyc;
    p100 = en_100M;
    p200 = en_200M;
  endtask

  // kind: 0 = nothing within budget, 1 = done, 2 = err; lat counted from the accept cycle.
  task automatic send(input logic sel, input bit hold, output int lat, output int kind);
    int w;
    w = 0;
    while (ifc.req_ready !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    tests++;
    if (w >= 100) begin
      fails++;
      $display("FAIL ready_wait: req_ready=%b after %0d cycles, want 1", ifc.req_ready, w);
    end
    ifc.req_valid = 1'b1;
    ifc.req_sel   = sel;
    t_acc = cyc;
    kind = 0;
    lat  = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (!hold) ifc.req_valid = 1'b0;
      if (ifc.done === 1'b1 || ifc.err === 1'b1) begin
        kind = (ifc.done === 1'b1) ? 1 : 2;
        lat  = k;
        break;
      end
    end
    ifc.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int d0, e0;
    rst = 1'b1;
    ifc.req_valid = 1'b0;
    ifc.req_sel   = 1'b0;
    repeat (3) tick();
    d0 = n_done;
    e0 = n_err;
    tests++;
    if ({en_200M, en_100M} !== 2'b01) begin
      fails++; $display("FAIL reset_en: {en_200M,en_100M}=%b want 01", {en_200M, en_100M});
    end
    tests++;
    if ({ifc.cur_sel, ifc.req_ready, ifc.busy} !== 3'b010) begin
      fails++; $display("FAIL reset_status: {cur_sel,ready,busy}=%b want 010",
                        {ifc.cur_sel, ifc.req_ready, ifc.busy});
    end
    tests++;
    if ({ifc.done, ifc.err} !== 2'b00) begin
      fails++; $display("FAIL reset_pulses: {done,err}=%b want 00", {ifc.done, ifc.err});
    end
    rst = 1'b0;
    repeat (6) tick();
    tests++;
    if (n_done != d0 || n_err != e0 || dbg_state !== ST_IDLE) begin
      fails++; $display("FAIL reset_idle: done=%0d err=%0d state=%0d want 0 0 IDLE",
                        n_done - d0, n_err - e0, dbg_state);
    end
  endtask

  task automatic test_switch(input logic sel);
    int lat, kind, fall_old, rise_new;
    fall100 = -1; rise100 = -1; fall200 = -1; rise200 = -1;
    send(sel, 1'b0, lat, kind);
    fall_old = sel ? fall100 : fall200;
    rise_new = sel ? rise200 : rise100;
    tests++;
    if (kind != 1 || lat != LAT_SW) begin
      fails++; $display("FAIL switch_done: kind=%0d lat=%0d want 1 %0d", kind, lat, LAT_SW);
    end
    tests++;
    if (ifc.cur_sel !== sel) begin
      fails++; $display("FAIL switch_cur_sel: got %b want %b", ifc.cur_sel, sel);
    end
    tests++;
    if (fall_old != t_acc + 1) begin
      fails++; $display("FAIL switch_old_fall: cycle %0d want %0d", fall_old, t_acc + 1);
    end
    tests++;
    if (rise_new != t_acc + 2 + S) begin
      fails++; $display("FAIL switch_new_rise: cycle %0d want %0d", rise_new, t_acc + 2 + S);
    end
    tick();
    tests++;
    if (ifc.req_ready !== 1'b1) begin
      fails++; $display("FAIL switch_ready_back: got %b want 1", ifc.req_ready);
    end
  endtask

  task automatic test_same(input logic sel);
    int lat, kind, b0;
    logic [1:0] en0;
    b0  = n_busy;
    en0 = {en_200M, en_100M};
    send(sel, 1'b0, lat, kind);
    tests++;
    if (kind != 1 || lat != 1) begin
      fails++; $display("FAIL same_done: kind=%0d lat=%0d want 1 1", kind, lat);
    end
    tests++;
    if ({en_200M, en_100M} !== en0 || n_busy != b0) begin
      fails++; $display("FAIL same_quiet: en=%b busy_cycles=%0d want %b 0",
                        {en_200M, en_100M}, n_busy - b0, en0);
    end
    tick();
    tests++;
    if (ifc.req_ready !== 1'b1) begin
      fails++; $display("FAIL same_ready_back: got %b want 1", ifc.req_ready);
    end
  endtask

  // Starts from cur_sel = 0: off-phase fault on 100M, then on-phase fault on 200M.
  task automatic test_timeouts();
    int lat, kind, d0;
    d0 = n_done;
    f100 = 1'b1; v100 = 1'b1;
    send(1'b1, 1'b0, lat, kind);
    f100 = 1'b0;
    tests++;
    if (kind != 2 || lat != LAT_OFF_TO) begin
      fails++; $display("FAIL off_timeout: kind=%0d lat=%0d want 2 %0d", kind, lat, LAT_OFF_TO);
    end
    tests++;
    if ({en_200M, en_100M, ifc.cur_sel} !== 3'b010) begin
      fails++; $display("FAIL off_timeout_restore: {en200,en100,cur}=%b want 010",
                        {en_200M, en_100M, ifc.cur_sel});
    end
    f200 = 1'b1; v200 = 1'b0;
    send(1'b1, 1'b0, lat, kind);
    f200 = 1'b0;
    tests++;
    if (kind != 2 || lat != LAT_ON_TO) begin
      fails++; $display("FAIL on_timeout: kind=%0d lat=%0d want 2 %0d", kind, lat, LAT_ON_TO);
    end
    tests++;
    if ({en_200M, en_100M, ifc.cur_sel} !== 3'b010 || n_done != d0) begin
      fails++; $display("FAIL on_timeout_restore: {en200,en100,cur}=%b dones=%0d want 010 0",
                        {en_200M, en_100M, ifc.cur_sel}, n_done - d0);
    end
  endtask

  task automatic test_busy_hold(input logic sel);
    int lat, kind, d0;
    d0 = n_done;
    send(sel, 1'b1, lat, kind);
    repeat (4) tick();
    tests++;
    if (kind != 1 || lat != LAT_SW || n_done - d0 != 1) begin
      fails++; $display("FAIL busy_hold: kind=%0d lat=%0d dones=%0d want 1 %0d 1",
                        kind, lat, n_done - d0, LAT_SW);
    end
  endtask

  // Starts from cur_sel = 1; resets while settling on 100M.
  task automatic test_reset_mid();
    int d0, e0, w;
    w = 0;
    while (ifc.req_ready !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    ifc.req_valid = 1'b1;
    ifc.req_sel   = 1'b0;
    t_acc = cyc;
    d0 = n_done;
    e0 = n_err;
    tick();
    ifc.req_valid = 1'b0;
    while (cyc < t_acc + 3 + 2 * S + 2) tick();
    tests++;
    if (dbg_state !== ST_SETTLE) begin
      fails++; $display("FAIL mid_in_settle: state=%0d want SETTLE", dbg_state);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({en_200M, en_100M, ifc.cur_sel, ifc.req_ready, ifc.busy} !== 5'b01010) begin
      fails++; $display("FAIL mid_reset_values: {en200,en100,cur,ready,busy}=%b want 01010",
                        {en_200M, en_100M, ifc.cur_sel, ifc.req_ready, ifc.busy});
    end
    while (cyc < t_acc + 30) tick();
    tests++;
    if (n_done != d0 || n_err != e0) begin
      fails++; $display("FAIL mid_no_pulse: dones=%0d errs=%0d want 0 0", n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_random(input int n);
    logic cur_m, sel;
    int   gap, fault, lat, kind, exp_lat, exp_kind;
    cur_m = ifc.cur_sel;
    for (int i = 0; i < n; i++) begin
      gap   = $urandom_range(0, 3);
      sel   = 1'($urandom_range(0, 1));
      fault = $urandom_range(0, 5);
      repeat (gap) tick();
      if (sel == cur_m) begin
        exp_kind = 1; exp_lat = 1;
      end else if (fault == 0) begin
        exp_kind = 2; exp_lat = LAT_OFF_TO;
        if (cur_m) begin f200 = 1'b1; v200 = 1'b1; end
        else       begin f100 = 1'b1; v100 = 1'b1; end
      end else if (fault == 1) begin
        exp_kind = 2; exp_lat = LAT_ON_TO;
        if (sel) begin f200 = 1'b1; v200 = 1'b0; end
        else     begin f100 = 1'b1; v100 = 1'b0; end
      end else begin
        exp_kind = 1; exp_lat = LAT_SW;
      end
      send(sel, 1'b0, lat, kind);
      f100 = 1'b0;
      f200 = 1'b0;
      if (exp_kind == 1) cur_m = sel;
      tests++;
      if (kind != exp_kind || lat != exp_lat) begin
        fails++; $display("FAIL rand_outcome[%0d]: kind=%0d lat=%0d want %0d %0d",
                          i, kind, lat, exp_kind, exp_lat);
      end
      tests++;
      if (ifc.cur_sel !== cur_m || {en_200M, en_100M} !== (cur_m ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL rand_state[%0d]: cur=%b en=%b want %b %b", i, ifc.cur_sel,
                          {en_200M, en_100M}, cur_m, (cur_m ? 2'b10 : 2'b01));
      end
    end
  endtask

  initial begin
    ifc.req_valid = 1'b0;
    ifc.req_sel   = 1'b0;
    test_reset();
    test_switch(1'b1);
    test_same(1'b1);
    test_switch(1'b0);
    test_same(1'b0);
    test_timeouts();
    test_busy_hold(1'b1);
    test_reset_mid();
    repeat (5) tick();
    test_random(40);
    tests++;
    if (viol != 0) begin
      fails++; $display("FAIL enable_overlap: %0d cycles with both enables high, want 0", viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
